mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single-port, word-addressed memory (one-cycle registered read, byte-masked write) between port 0 (CPU) and port 1 (loader/debug master). It sits between both masters and the memory's `mem_addr`/`mem_rstrb`/`mem_rdata`/`mem_wdata`/`mem_wmask` pins. It serialises accesses, selects the winner by round-robin or fixed priority, and returns a one-cycle completion pulse to the winner.

## Interface
- `ROUND_ROBIN`, default 1: 1 = alternate on contention; 0 = port 0 always wins.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `p0_addr`, `p1_addr`  in  32 each  byte address; memory uses bits [31:2].
- `p0_rstrb`, `p1_rstrb`  in  1 each  read request level.
- `p0_wdata`, `p1_wdata`  in  32 each  write data, already lane-aligned.
- `p0_wmask`, `p1_wmask`  in  4 each  byte-write enables; nonzero = write request.
- `p0_rdata`, `p1_rdata`  out  32 each  both wired to `mem_rdata`; valid only while that port's `ready` is high.
- `p0_ready`, `p1_ready`  out  1 each  registered one-cycle completion pulse.
- `mem_addr`  out  32  to memory.
- `mem_rstrb`  out  1  to memory.
- `mem_wdata`  out  32  to memory.
- `mem_wmask`  out  4  to memory.
- `mem_rdata`  in  32  from memory; valid the cycle after `mem_rstrb`.
- `owner`  out  1  port of the last grant (debug).

## Operation
- Request rule: port *n* is pending when `pn_rstrb | (|pn_wmask)`. The master holds addr, wdata, wmask and rstrb stable from assertion through the cycle its `ready` is high. It drops or changes them on the following cycle.
- State machine has two states, IDLE and DONE.
  - IDLE, no request pending: `mem_rstrb=0`, `mem_wmask=0`, and `mem_addr`/`mem_wdata` are don't-care. Stay in IDLE.
  - IDLE, one or more requests pending:
    - Choose a winner.
    - Drive the winner's addr, rstrb, wdata and wmask onto the `mem_*` outputs combinationally in the same cycle.
    - Register the winner into `owner`.
    - Go to DONE.
  - DONE: `mem_rstrb=0` and `mem_wmask=0`, so no issue happens in this cycle. `p<owner>_ready=1`. Go to IDLE.
- Winner selection:
  - Only one port pending: that port wins.
  - Both pending with `ROUND_ROBIN=1`: the port that is not `owner` wins.
  - Both pending with `ROUND_ROBIN=0`: port 0 wins.
- Combined read+write (rstrb and nonzero wmask together): both strobes are forwarded. The memory returns the pre-write word, and one `ready` covers both.
- `ready` outputs are flops set on the IDLE→DONE edge and cleared on the next edge. Only one port's ready is ever high.
- `rdata` is not muxed or registered. It is a direct pass-through of `mem_rdata`.

## Timing
- Reset values:
  - state = IDLE
  - `owner` = 1, so port 0 wins the first tie
  - `p0_ready` = 0, `p1_ready` = 0
  - `mem_rstrb` = 0, `mem_wmask` = 0 while `reset` is high, whatever the requests are.
- Latency: request seen in IDLE at cycle T leads to the memory strobe in T and `ready` (plus read data) in T+1. Minimum latency is 1 cycle.
- Throughput: at most one access every 2 cycles in total. Under continuous contention with `ROUND_ROBIN=1`, grants alternate 0,1,0,1…
- Fixed-priority mode: port 1 can starve indefinitely. This is intentional.
- A request arriving during DONE is not sampled until the following IDLE cycle.
- Reset asserted in DONE: `ready` is forced low and the completion is lost. The write has already been committed to memory. The master must reissue reads.
- Reset asserted in the IDLE issue cycle: strobes are forced low, so no memory access occurs.
- A requester that drops its request before `ready` violates protocol and the behaviour is undefined. The bench must not do this.

## Test plan
- Write, then read: port 0 writes 0x400 with data 0xDEADBEEF and wmask 0xF, then reads 0x400. Each op gives `p0_ready` exactly 1 cycle after issue, and the read returns `p0_rdata`=0xDEADBEEF. `p1_ready` stays 0 throughout.
- Byte write: 0x404 is preloaded with 0x00000000. Port 1 writes data 0x0000AB00 with wmask 0x2. A read of 0x404 then returns 0x0000AB00.
- Round-robin contention: out of reset, both ports hold reads (p0 at 0x400, p1 at 0x404) and re-request right after each `ready`. Grants go p0,p1,p0,p1, and each port sees a ready every 4 cycles.
- Fixed priority: with `ROUND_ROBIN=0`, both ports hold requests continuously for 20 cycles. `p0_ready` pulses 10 times and `p1_ready` never pulses.
- Reset mid-op: port 0 writes 0x55 to byte 0x408 with wmask 0x1, and `reset` is asserted in the DONE cycle. `p0_ready` stays 0. A read after reset returns byte 0x55.
- Idle: with no requests for 10 cycles, `mem_rstrb` and `mem_wmask` stay 0 and both `ready` outputs stay 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one single-port, word-addressed memory (one-cycle registered read,
// byte-masked write) between port 0 (CPU) and port 1 (loader/debug master).
// Each access takes two cycles. In IDLE the winner's request is put straight
// onto the memory pins. In DONE the winner gets a one-cycle ready pulse.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   pN_addr/rstrb/        per-port request: byte address, read strobe level,
//   pN_wdata/wmask        lane-aligned write data, byte enables
//   pN_rdata              direct copy of mem_rdata (valid while pN_ready)
//   pN_ready              one-cycle completion pulse to the granted port
//   mem_addr/rstrb/       request forwarded to the memory
//   mem_wdata/wmask
//   mem_rdata             memory read data, valid the cycle after mem_rstrb
//   owner                 port of the most recent grant (debug)
//
// Parameter
//   ROUND_ROBIN           1: alternate between ports on contention
//                         0: port 0 always wins (port 1 may starve)

module mem_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] p0_addr,
    input  logic        p0_rstrb,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wmask,
    output logic [31:0] p0_rdata,
    output logic        p0_ready,
    input  logic [31:0] p1_addr,
    input  logic        p1_rstrb,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wmask,
    output logic [31:0] p1_rdata,
    output logic        p1_ready,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    output logic        owner
);

    typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;

    state_t state;
    logic   p0_pend;
    logic   p1_pend;
    logic   any_pend;
    logic   win;
    logic   issue;
    logic   p0_ready_q;
    logic   p1_ready_q;

    assign p0_pend  = p0_rstrb | (|p0_wmask);
    assign p1_pend  = p1_rstrb | (|p1_wmask);
    assign any_pend = p0_pend | p1_pend;

    // Winner: a lone requester always wins. On a tie, round-robin hands the
    // grant to the port that did not win last time. Fixed priority favours
    // port 0.
    always_comb begin
        win = 1'b0;
        if (p0_pend && p1_pend) begin
            win = (ROUND_ROBIN != 0) ? ~owner : 1'b0;
        end else begin
            win = p1_pend;
        end
    end

    // The memory access happens in the IDLE cycle itself. Reset suppresses
    // the strobes so no access slips through during reset.
    assign issue = (state == IDLE) && any_pend && !reset;

    assign mem_addr  = win ? p1_addr  : p0_addr;
    assign mem_wdata = win ? p1_wdata : p0_wdata;
    assign mem_rstrb = issue & (win ? p1_rstrb : p0_rstrb);
    assign mem_wmask = issue ? (win ? p1_wmask : p0_wmask) : 4'b0000;

    assign p0_rdata = mem_rdata;
    assign p1_rdata = mem_rdata;

    // The ready flops are masked by reset. This means a reset landing in DONE
    // drops the completion within that same cycle.
    assign p0_ready = p0_ready_q & ~reset;
    assign p1_ready = p1_ready_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b1;
            p0_ready_q <= 1'b0;
            p1_ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        state      <= DONE;
                        owner      <= win;
                        p0_ready_q <= ~win;
                        p1_ready_q <= win;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    p0_ready_q <= 1'b0;
                    p1_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a memory model plus directed scenarios, followed by
// randomized two-master traffic. The randomized traffic is scored by a
// transaction-level model: a shadow memory and rules for grant order and latency.

module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Request fields for the round-robin instance, indexed by port
    logic [31:0] q_addr  [2];
    logic [31:0] q_wdata [2];
    logic [3:0]  q_wmask [2];
    logic        q_rstrb [2];

    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        p0_ready, p1_ready, mem_rstrb, owner;
    logic [3:0]  mem_wmask;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p0_addr   (q_addr[0]),
        .p0_rstrb  (q_rstrb[0]),
        .p0_wdata  (q_wdata[0]),
        .p0_wmask  (q_wmask[0]),
        .p0_rdata  (p0_rdata),
        .p0_ready  (p0_ready),
        .p1_addr   (q_addr[1]),
        .p1_rstrb  (q_rstrb[1]),
        .p1_wdata  (q_wdata[1]),
        .p1_wmask  (q_wmask[1]),
        .p1_rdata  (p1_rdata),
        .p1_ready  (p1_ready),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    // Fixed-priority instance, used only for the starvation scenario
    logic        f_rstrb0, f_rstrb1;
    logic [31:0] f_p0_rdata, f_p1_rdata, f_mem_addr, f_mem_wdata;
    logic        f_p0_ready, f_p1_ready, f_mem_rstrb, f_owner;
    logic [3:0]  f_mem_wmask;

    mem_arbiter #(.ROUND_ROBIN(0)) dut_fp (
        .clk       (clk),
        .reset     (reset),
        .p0_addr   (32'h0000_0400),
        .p0_rstrb  (f_rstrb0),
        .p0_wdata  (32'h0),
        .p0_wmask  (4'h0),
        .p0_rdata  (f_p0_rdata),
        .p0_ready  (f_p0_ready),
        .p1_addr   (32'h0000_0404),
        .p1_rstrb  (f_rstrb1),
        .p1_wdata  (32'h0),
        .p1_wmask  (4'h0),
        .p1_rdata  (f_p1_rdata),
        .p1_ready  (f_p1_ready),
        .mem_addr  (f_mem_addr),
        .mem_rstrb (f_mem_rstrb),
        .mem_wdata (f_mem_wdata),
        .mem_wmask (f_mem_wmask),
        .mem_rdata (32'h0),
        .owner     (f_owner)
    );

    // Memory: one-cycle registered read of the pre-write word, byte-masked write
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_rstrb) mem_rdata <= mem[mem_addr[11:2]];
        for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    int tests = 0;
    int fails = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_port(input int n, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] wm, input logic rs);
        q_addr[n]  = a;
        q_wdata[n] = wd;
        q_wmask[n] = wm;
        q_rstrb[n] = rs;
    endtask

    task automatic clr_port(input int n);
        set_port(n, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    function automatic logic rdy_of(input int n);
        return (n == 1) ? p1_ready : p0_ready;
    endfunction

    // The arbiter is expected to be idle with no requests on entry. Returns the
    // read data seen during the ready cycle.
    task automatic do_op(input int n, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] wm, input logic rs, output logic [31:0] rd);
        next();
        set_port(n, a, wd, wm, rs);
        settle();
        chk("op_issue_rstrb", 32'(mem_rstrb), 32'(rs));
        chk("op_issue_wmask", 32'(mem_wmask), 32'(wm));
        chk("op_issue_addr", mem_addr, a);
        chk("op_issue_no_ready", 32'(p0_ready | p1_ready), 0);
        next();
        settle();
        chk("op_ready", 32'(rdy_of(n)), 1);
        chk("op_other_ready", 32'(rdy_of(1 - n)), 0);
        chk("op_done_quiet", 32'({mem_rstrb, mem_wmask}), 0);
        chk("op_owner", 32'(owner), n);
        rd = (n == 1) ? p1_rdata : p0_rdata;
        next();
        clr_port(n);
        settle();
        chk("op_ready_one_cycle", 32'(p0_ready | p1_ready), 0);
    endtask

    logic [31:0] rd;
    logic [31:0] ref_mem [8];
    logic        act [2];
    logic        seen [2];
    logic        pend_prev [2];
    int          age [2];
    int          last_g;
    int          cnt0, cnt1;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;
        clr_port(0);
        clr_port(1);
        f_rstrb0 = 1'b0;
        f_rstrb1 = 1'b0;

        // Reset with requests present: no strobes, no ready, owner = 1
        reset = 1'b1;
        set_port(0, 32'h400, 32'h0, 4'h0, 1'b1);
        set_port(1, 32'h404, 32'h1234, 4'hF, 1'b0);
        next();
        next();
        settle();
        chk("rst_rstrb", 32'(mem_rstrb), 0);
        chk("rst_wmask", 32'(mem_wmask), 0);
        chk("rst_p0_ready", 32'(p0_ready), 0);
        chk("rst_p1_ready", 32'(p1_ready), 0);
        chk("rst_owner", 32'(owner), 1);
        next();
        reset = 1'b0;
        clr_port(0);
        clr_port(1);
        settle();

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            next();
            settle();
            chk("idle_quiet", 32'({mem_rstrb, mem_wmask}), 0);
            chk("idle_ready", 32'({p0_ready, p1_ready}), 0);
        end

        // Write then read on port 0
        do_op(0, 32'h400, 32'hDEADBEEF, 4'hF, 1'b0, rd);
        do_op(0, 32'h400, 32'h0, 4'h0, 1'b1, rd);
        chk("wr_rd_data", rd, 32'hDEADBEEF);

        // Byte write on port 1 into a zeroed word
        do_op(0, 32'h404, 32'h0, 4'hF, 1'b0, rd);
        do_op(1, 32'h404, 32'h0000AB00, 4'h2, 1'b0, rd);
        do_op(1, 32'h404, 32'h0, 4'h0, 1'b1, rd);
        chk("byte_wr_data", rd, 32'h0000AB00);

        // Round-robin contention straight out of reset
        next();
        reset = 1'b1;
        settle();
        next();
        reset = 1'b0;
        set_port(0, 32'h400, 32'h0, 4'h0, 1'b1);
        set_port(1, 32'h404, 32'h0, 4'h0, 1'b1);
        settle();
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                next();
                settle();
            end
            chk("rr_p0_ready", 32'(p0_ready), 32'((k % 4) == 1));
            chk("rr_p1_ready", 32'(p1_ready), 32'((k % 4) == 3));
            if ((k % 2) == 0) begin
                chk("rr_issue_addr", mem_addr, ((k % 4) == 0) ? 32'h400 : 32'h404);
                chk("rr_issue_rstrb", 32'(mem_rstrb), 1);
            end else begin
                chk("rr_owner", 32'(owner), 32'((k % 4) == 3));
                chk("rr_rdata", ((k % 4) == 1) ? p0_rdata : p1_rdata,
                    ((k % 4) == 1) ? 32'hDEADBEEF : 32'h0000AB00);
            end
        end
        next();
        clr_port(0);
        clr_port(1);
        settle();

        // Fixed priority: port 1 starves
        next();
        f_rstrb0 = 1'b1;
        f_rstrb1 = 1'b1;
        settle();
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 20; i++) begin
            next();
            settle();
            cnt0 += int'(f_p0_ready);
            cnt1 += int'(f_p1_ready);
        end
        next();
        f_rstrb0 = 1'b0;
        f_rstrb1 = 1'b0;
        settle();
        chk("fp_p0_count", cnt0, 10);
        chk("fp_p1_count", cnt1, 0);

        // Reset in the DONE cycle of a byte write
        next();
        set_port(0, 32'h408, 32'h00000055, 4'h1, 1'b0);
        settle();
        chk("rmid_issue_wmask", 32'(mem_wmask), 32'h1);
        next();
        reset = 1'b1;
        settle();
        chk("rmid_ready_done", 32'(p0_ready), 0);
        next();
        reset = 1'b0;
        clr_port(0);
        settle();
        chk("rmid_ready_after", 32'(p0_ready | p1_ready), 0);
        do_op(0, 32'h408, 32'h0, 4'h0, 1'b1, rd);
        chk("rmid_readback", rd, 32'h00000055);

        // Randomized traffic from both masters. The last grant above went to port 0.
        last_g = 0;
        for (int n = 0; n < 2; n++) begin
            act[n] = 1'b0;
            seen[n] = 1'b0;
            pend_prev[n] = 1'b0;
            age[n] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            next();
            for (int n = 0; n < 2; n++) begin
                if (seen[n]) begin
                    act[n] = 1'b0;
                    seen[n] = 1'b0;
                    clr_port(n);
                end
                if (!act[n] && c < 360 && $urandom_range(0, 2) != 0) begin
                    int kind;
                    logic [31:0] a;
                    logic [3:0]  wm;
                    kind = $urandom_range(0, 2);
                    a = 32'h500 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
                    wm = (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    set_port(n, a, $urandom, wm, kind != 1);
                    act[n] = 1'b1;
                    age[n] = 0;
                end else if (act[n]) begin
                    age[n]++;
                end
            end
            settle();
            chk("rnd_single_ready", 32'(p0_ready & p1_ready), 0);
            for (int n = 0; n < 2; n++) begin
                if (rdy_of(n)) begin
                    logic [2:0] idx;
                    chk("rnd_ready_has_req", 32'(act[n]), 1);
                    chk("rnd_latency", 32'(age[n] <= 4), 1);
                    idx = q_addr[n][4:2];
                    if (q_rstrb[n])
                        chk("rnd_rdata", (n == 1) ? p1_rdata : p0_rdata, ref_mem[idx]);
                    for (int b = 0; b < 4; b++)
                        if (q_wmask[n][b]) ref_mem[idx][8*b +: 8] = q_wdata[n][8*b +: 8];
                    if (pend_prev[0] && pend_prev[1])
                        chk("rnd_rr_alternate", n, 1 - last_g);
                    chk("rnd_owner", 32'(owner), n);
                    last_g = n;
                    seen[n] = 1'b1;
                end else if (act[n]) begin
                    chk("rnd_pending_age", 32'(age[n] < 4), 1);
                end
            end
            pend_prev[0] = act[0];
            pend_prev[1] = act[1];
        end
        chk("rnd_drained", 32'(act[0] | act[1]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
